m_axil_master: RTL

M_AXIL_MASTER -- requirements
Module: m_axil_master

---
 rtl/m_axil_master.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/m_axil_master.sv
// m_axil_master
//   Single-outstanding AXI-Lite master. A simple command/response handshake
//   on the user side is converted into one AXI-Lite write (AW + W, then B)
//   or read (AR, then R) transaction. All AXI outputs are registered.
//
// Ports
//   ACLK, ARESET            clock (rising edge), synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake; cmd_ready is high only when idle
//   cmd_write               1 = write, 0 = read
//   cmd_addr/wdata/wstrb    command address, write data, byte enables
//   rsp_valid / rsp_ready   response handshake
//   rsp_write               type of the completed command
//   rsp_rdata               read data (0 for writes and timeouts)
//   rsp_resp                BRESP/RRESP, or 2'b10 on watchdog timeout
//   AW*/W*/B*/AR*/R*        AXI-Lite master channels
//
// Build option
//   M_AXIL_MASTER_TIMEOUT_EN  when defined, a watchdog ends any transaction
//                             that stays busy for TIMEOUT_CYCLES cycles with
//                             an SLVERR response. Undefined: waits forever.

module m_axil_master #(
    parameter int unsigned M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                      rsp_resp,

    output logic [M_AXI_ADDR_WIDTH-1:0]     AWADDR,
    output logic                            AWVALID,
    input  logic                            AWREADY,

    output logic [M_AXI_DATA_WIDTH-1:0]     WDATA,
    output logic [M_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    output logic                            WVALID,
    input  logic                            WREADY,

    input  logic [1:0]                      BRESP,
    input  logic                            BVALID,
    output logic                            BREADY,

    output logic [M_AXI_ADDR_WIDTH-1:0]     ARADDR,
    output logic                            ARVALID,
    input  logic                            ARREADY,

    input  logic [M_AXI_DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                      RRESP,
    input  logic                            RVALID,
    output logic                            RREADY
);

    localparam int unsigned STRB_W = M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP
    } state_t;

    state_t                         state_q, state_d;

    logic [M_AXI_ADDR_WIDTH-1:0]    addr_q,      addr_d;
    logic [M_AXI_DATA_WIDTH-1:0]    wdata_q,     wdata_d;
    logic [STRB_W-1:0]              wstrb_q,     wstrb_d;
    logic                           awvalid_q,   awvalid_d;
    logic                           wvalid_q,    wvalid_d;
    logic                           aw_done_q,   aw_done_d;
    logic                           w_done_q,    w_done_d;
    logic                           bready_q,    bready_d;
    logic                           arvalid_q,   arvalid_d;
    logic                           rready_q,    rready_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic                           rsp_write_q, rsp_write_d;
    logic [M_AXI_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                     rsp_resp_q,  rsp_resp_d;

    logic                           accept;
    logic                           busy;
    logic                           aw_hs;
    logic                           w_hs;
    logic                           tmo_hit;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q == WR) || (state_q == WB) ||
                       (state_q == RA) || (state_q == RD);

    // VALID registers are only ever high in WR, so these need no state term.
    assign aw_hs = awvalid_q && AWREADY;
    assign w_hs  = wvalid_q  && WREADY;

`ifdef M_AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tmo_cnt_q <= '0;
        end else if (accept) begin
            tmo_cnt_q <= '0;
        end else if (busy && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
`else
    // Watchdog limit only matters when the watchdog is built in.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    rsp_write_d = cmd_write;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RA;
                    end
                end
            end

            WR: begin
                // AW and W finish independently; leave once both are done,
                // counting a handshake happening in this very cycle.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WB;
                end
            end

            WB: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = BRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RA: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD;
                end
            end

            RD: begin
                if (RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog overrides whatever the channel logic decided this cycle.
        if (tmo_hit) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Address/data come straight from the command registers, which only
    // change in IDLE, so they are stable whenever a VALID is high.
    assign AWADDR    = addr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule
